sort_cmd_arbiter: RTL and testbench

//  Two-requester round-robin arbiter and sequencer in front of the quicksort engine's toggle command port.

---
 rtl/sort_cmd_arbiter_if.sv | 25 ++
 rtl/sort_cmd_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_sort_cmd_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sort_cmd_arbiter_if.sv
// Requester-side command/response bundle for the sort engine arbiter.
// The master side issues commands; the slave side (arbiter) grants and responds.
interface sort_cmd_arbiter_if #(
  parameter int unsigned D_MSB = 7
) ();
  logic [1:0]     req_valid;
  logic [1:0]     req_op0;
  logic [1:0]     req_op1;
  logic [D_MSB:0] req_data0;
  logic [D_MSB:0] req_data1;
  logic [1:0]     req_ready;
  logic [1:0]     rsp_valid;
  logic [D_MSB:0] rsp_data;
  logic           rsp_err;

  modport master (
    output req_valid, req_op0, req_op1, req_data0, req_data1,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_op0, req_op1, req_data0, req_data1,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/sort_cmd_arbiter.sv
// Two-requester round-robin arbiter that turns one command at a time into a single
// toggle on the sort engine's command lines and returns a one-cycle response.
module sort_cmd_arbiter #(
  parameter int unsigned     D_MSB   = 7,
  parameter int unsigned     TO_MSB  = 15,
  parameter logic [TO_MSB:0] TIMEOUT = 16'hFFFF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  sort_cmd_arbiter_if.slave  cmd,
  output logic               busy,
  output logic               owner,
  output logic               eng_push,
  output logic               eng_pop,
  output logic               eng_clear,
  output logic               eng_sort,
  output logic [D_MSB:0]     eng_data,
  input  logic               eng_idle,
  input  logic               eng_full,
  input  logic               eng_empty,
  input  logic [D_MSB:0]     eng_rdata
);

  localparam logic [1:0] OpPush  = 2'b00;
  localparam logic [1:0] OpPop   = 2'b01;
  localparam logic [1:0] OpClear = 2'b10;
  localparam logic [1:0] OpSort  = 2'b11;

  localparam logic [TO_MSB:0] CntOne = (TO_MSB + 1)'(1);
  localparam logic [TO_MSB:0] ToLast = TIMEOUT - CntOne;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StGuard,
    StWait,
    StResp
  } state_e;

  state_e          state_q;
  logic [1:0]      op_q;
  logic [D_MSB:0]  data_q;
  logic            owner_q;
  logic            lp_q;
  logic [TO_MSB:0] cnt_q;
  logic [1:0]      rsp_valid_q;
  logic [D_MSB:0]  rsp_data_q;
  logic            rsp_err_q;
  logic            push_q;
  logic            pop_q;
  logic            clear_q;
  logic            sort_q;

  logic            accept;
  logic            grant;
  logic [1:0]      req_ready;
  logic [1:0]      sel_op;
  logic [D_MSB:0]  sel_data;
  logic [1:0]      owner_vec;
  logic            reject;
  logic            wdog_hit;

  // Grant: lone valid bit wins, a tie goes to the requester that did not win last.
  always_comb begin
    accept    = 1'b0;
    grant     = 1'b0;
    req_ready = 2'b00;
    if (state_q == StIdle && enable && eng_idle && (|cmd.req_valid)) begin
      accept = 1'b1;
      unique case (cmd.req_valid)
        2'b01:   grant = 1'b0;
        2'b10:   grant = 1'b1;
        default: grant = ~lp_q;
      endcase
      req_ready = grant ? 2'b10 : 2'b01;
    end
  end

  always_comb begin
    sel_op    = grant ? cmd.req_op1 : cmd.req_op0;
    sel_data  = grant ? cmd.req_data1 : cmd.req_data0;
    owner_vec = owner_q ? 2'b10 : 2'b01;
    reject    = (op_q == OpPush && eng_full) || (op_q == OpPop && eng_empty);
    wdog_hit  = (TIMEOUT != '0) && (cnt_q == ToLast);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      op_q        <= OpPush;
      data_q      <= '0;
      owner_q     <= 1'b0;
      lp_q        <= 1'b1;
      cnt_q       <= '0;
      rsp_valid_q <= 2'b00;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      push_q      <= 1'b0;
      pop_q       <= 1'b0;
      clear_q     <= 1'b0;
      sort_q      <= 1'b0;
    end else begin
      // Response fields are only non-zero during the single RESP cycle.
      rsp_valid_q <= 2'b00;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            op_q    <= sel_op;
            data_q  <= sel_data;
            owner_q <= grant;
            lp_q    <= grant;
            state_q <= StIssue;
          end
        end
        StIssue: begin
          if (!enable || reject) begin
            rsp_valid_q <= owner_vec;
            rsp_err_q   <= 1'b1;
            state_q     <= StResp;
          end else begin
            unique case (op_q)
              OpPush:  push_q  <= ~push_q;
              OpPop:   pop_q   <= ~pop_q;
              OpClear: clear_q <= ~clear_q;
              OpSort:  sort_q  <= ~sort_q;
              default: ;
            endcase
            state_q <= StGuard;
          end
        end
        StGuard: begin
          // eng_idle is still stale here; the engine is only now registering the toggle.
          cnt_q <= '0;
          if (!enable) begin
            rsp_valid_q <= owner_vec;
            rsp_err_q   <= 1'b1;
            state_q     <= StResp;
          end else begin
            state_q <= StWait;
          end
        end
        StWait: begin
          if (!enable) begin
            rsp_valid_q <= owner_vec;
            rsp_err_q   <= 1'b1;
            state_q     <= StResp;
          end else if (eng_idle) begin
            rsp_valid_q <= owner_vec;
            rsp_data_q  <= (op_q == OpPop) ? eng_rdata : '0;
            state_q     <= StResp;
          end else if (wdog_hit) begin
            rsp_valid_q <= owner_vec;
            rsp_err_q   <= 1'b1;
            state_q     <= StResp;
          end else begin
            cnt_q <= cnt_q + CntOne;
          end
        end
        StResp: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign cmd.req_ready = req_ready;
  assign cmd.rsp_valid = rsp_valid_q;
  assign cmd.rsp_data  = rsp_data_q;
  assign cmd.rsp_err   = rsp_err_q;

  assign busy      = (state_q != StIdle);
  assign owner     = owner_q;
  assign eng_push  = push_q;
  assign eng_pop   = pop_q;
  assign eng_clear = clear_q;
  assign eng_sort  = sort_q;
  assign eng_data  = data_q;

endmodule

// File: tb/tb_sort_cmd_arbiter.sv
// Directed bench for sort_cmd_arbiter: a small stack/sort engine model answers the
// toggles, and expected responses queue up at accept time and are checked on rsp_valid.
module tb_sort_cmd_arbiter;

  localparam int         SortExtra = 2;
  localparam int         Depth     = 4;
  localparam logic [1:0] OpPush    = 2'b00;
  localparam logic [1:0] OpPop     = 2'b01;
  localparam logic [1:0] OpClear   = 2'b10;
  localparam logic [1:0] OpSort    = 2'b11;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       busy;
  logic       owner;
  logic       eng_push, eng_pop, eng_clear, eng_sort;
  logic [7:0] eng_data;
  logic       eng_idle, eng_full, eng_empty;
  logic [7:0] eng_rdata;

  sort_cmd_arbiter_if #(.D_MSB(7)) cmd_if ();

  sort_cmd_arbiter #(
    .D_MSB  (7),
    .TO_MSB (15),
    .TIMEOUT(16'd4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .cmd      (cmd_if),
    .busy     (busy),
    .owner    (owner),
    .eng_push (eng_push),
    .eng_pop  (eng_pop),
    .eng_clear(eng_clear),
    .eng_sort (eng_sort),
    .eng_data (eng_data),
    .eng_idle (eng_idle),
    .eng_full (eng_full),
    .eng_empty(eng_empty),
    .eng_rdata(eng_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Engine model: a stack that sees each toggle one edge after the arbiter drives it.
  wire [3:0]  tog = {eng_sort, eng_clear, eng_pop, eng_push};
  logic [3:0] prev_tog = 4'b0;
  logic [7:0] mem [Depth];
  int         ecnt = 0;
  int         busy_cnt = 0;
  logic [7:0] rdata = 8'h00;
  logic       force_busy = 1'b0;

  assign eng_idle  = (tog == prev_tog) && (busy_cnt == 0) && !force_busy;
  assign eng_full  = (ecnt == Depth);
  assign eng_empty = (ecnt == 0);
  assign eng_rdata = rdata;

  always @(posedge clk) begin
    logic [7:0] t;
    if (rst) begin
      prev_tog <= 4'b0;
      busy_cnt <= 0;
      ecnt     <= 0;
      rdata    <= 8'h00;
    end else if (!enable) begin
      prev_tog <= tog;
      busy_cnt <= 0;
    end else begin
      if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
      if (tog != prev_tog) begin
        prev_tog <= tog;
        if (tog[0] != prev_tog[0] && ecnt < Depth) begin
          mem[ecnt] = eng_data;
          ecnt <= ecnt + 1;
        end
        if (tog[1] != prev_tog[1] && ecnt > 0) begin
          rdata <= mem[ecnt-1];
          ecnt  <= ecnt - 1;
        end
        if (tog[2] != prev_tog[2]) ecnt <= 0;
        if (tog[3] != prev_tog[3]) begin
          for (int i = 0; i < ecnt; i++)
            for (int j = 0; j + 1 < ecnt - i; j++)
              if (mem[j] > mem[j+1]) begin
                t = mem[j]; mem[j] = mem[j+1]; mem[j+1] = t;
              end
          busy_cnt <= SortExtra;
        end
      end
    end
  end

  typedef struct {
    logic [1:0] vld;
    logic [7:0] data;
    logic       err;
    logic [3:0] tog;
    int         lat;
  } exp_t;

  exp_t       sb[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         acc_cyc = 0;
  logic [3:0] tog_acc = 4'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cmd_if.req_valid = 2'b00;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_accept(output int gr);
    bit got;
    got = 1'b0;
    gr  = -1;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (cmd_if.req_ready != 2'b00) begin
        got     = 1'b1;
        gr      = cmd_if.req_ready[1] ? 1 : 0;
        acc_cyc = cyc;
        tog_acc = tog;
      end else begin
        tick();
      end
    end
    check("accept_seen", 32'(got), 32'd1);
  endtask

  task automatic push_exp(input int gr, input logic [7:0] d, input logic err,
                          input logic [3:0] t, input int lat);
    exp_t e;
    e.vld  = (gr == 1) ? 2'b10 : 2'b01;
    e.data = d;
    e.err  = err;
    e.tog  = t;
    e.lat  = lat;
    sb.push_back(e);
  endtask

  task automatic wait_rsp(input string tag);
    bit   got;
    exp_t e;
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (cmd_if.rsp_valid != 2'b00) got = 1'b1;
    end
    check({tag, "_seen"}, 32'(got), 32'd1);
    check({tag, "_sb"}, 32'(sb.size() != 0), 32'd1);
    if (got && sb.size() != 0) begin
      e = sb.pop_front();
      check({tag, "_vld"}, 32'(cmd_if.rsp_valid), 32'(e.vld));
      check({tag, "_data"}, 32'(cmd_if.rsp_data), 32'(e.data));
      check({tag, "_err"}, 32'(cmd_if.rsp_err), 32'(e.err));
      check({tag, "_tog"}, 32'(tog ^ tog_acc), 32'(e.tog));
      check({tag, "_lat"}, 32'(cyc - acc_cyc), 32'(e.lat));
    end
  endtask

  task automatic send(input int r, input logic [1:0] op, input logic [7:0] d,
                      input logic [7:0] exp_d, input logic exp_err, input int lat,
                      input string tag);
    int gr;
    if (r == 0) begin
      cmd_if.req_op0   = op;
      cmd_if.req_data0 = d;
    end else begin
      cmd_if.req_op1   = op;
      cmd_if.req_data1 = d;
    end
    cmd_if.req_valid[r] = 1'b1;
    wait_accept(gr);
    check({tag, "_grant"}, 32'(gr), 32'(r));
    push_exp(r, exp_d, exp_err, exp_err ? 4'b0000 : (4'b0001 << op), lat);
    tick();
    cmd_if.req_valid[r] = 1'b0;
    wait_rsp(tag);
    tick();
  endtask

  initial begin
    int         gr;
    logic [1:0] seen_vld;
    cmd_if.req_valid = 2'b00;
    cmd_if.req_op0   = OpPush;
    cmd_if.req_op1   = OpPush;
    cmd_if.req_data0 = 8'h00;
    cmd_if.req_data1 = 8'h00;

    // Reset state, with enable low so a pending request must not be granted.
    do_reset();
    cmd_if.req_valid = 2'b01;
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_owner", 32'(owner), 32'd0);
    check("rst_rsp_valid", 32'(cmd_if.rsp_valid), 32'd0);
    check("rst_rsp_err", 32'(cmd_if.rsp_err), 32'd0);
    check("rst_rsp_data", 32'(cmd_if.rsp_data), 32'd0);
    check("rst_toggles", 32'(tog), 32'd0);
    check("rst_eng_data", 32'(eng_data), 32'd0);
    check("no_grant_disabled", 32'(cmd_if.req_ready), 32'd0);
    tick();
    cmd_if.req_valid = 2'b00;
    enable = 1'b1;

    // Single push on an idle engine.
    send(0, OpPush, 8'h5A, 8'h00, 1'b0, 4, "push5a");
    check("eng_data_hold", 32'(eng_data), 32'h5A);

    // Push three, sort from requester 1, pop three from requester 0.
    do_reset();
    send(0, OpPush, 8'h33, 8'h00, 1'b0, 4, "push33");
    send(0, OpPush, 8'h11, 8'h00, 1'b0, 4, "push11");
    send(0, OpPush, 8'h22, 8'h00, 1'b0, 4, "push22");
    send(1, OpSort, 8'h00, 8'h00, 1'b0, 4 + SortExtra, "sort");
    send(0, OpPop, 8'h00, 8'h33, 1'b0, 4, "pop_a");
    send(0, OpPop, 8'h00, 8'h22, 1'b0, 4, "pop_b");
    send(0, OpPop, 8'h00, 8'h11, 1'b0, 4, "pop_c");

    // Rejections: pop on empty, push on full.
    send(0, OpPop, 8'h00, 8'h00, 1'b1, 2, "pop_empty");
    for (int i = 0; i < Depth; i++) send(1, OpPush, 8'(8'h80 + i), 8'h00, 1'b0, 4, "fill");
    send(1, OpPush, 8'hEE, 8'h00, 1'b1, 2, "push_full");
    send(0, OpClear, 8'h00, 8'h00, 1'b0, 4, "clear");

    // Watchdog: engine held busy after the toggle.
    cmd_if.req_op0   = OpPush;
    cmd_if.req_data0 = 8'h77;
    cmd_if.req_valid = 2'b01;
    wait_accept(gr);
    push_exp(0, 8'h00, 1'b1, 4'b0001, 7);
    tick();
    cmd_if.req_valid = 2'b00;
    force_busy = 1'b1;
    wait_rsp("timeout");
    tick();
    @(negedge clk);
    check("timeout_idle", 32'(busy), 32'd0);
    force_busy = 1'b0;
    tick();

    // Enable dropped in the first WAIT cycle of a sort.
    cmd_if.req_op1   = OpSort;
    cmd_if.req_valid = 2'b10;
    wait_accept(gr);
    check("en_drop_grant", 32'(gr), 32'd1);
    push_exp(1, 8'h00, 1'b1, 4'b1000, 4);
    tick();
    cmd_if.req_valid = 2'b00;
    tick();
    tick();
    enable = 1'b0;
    wait_rsp("en_drop");
    enable = 1'b1;
    tick();

    // Reset in GUARD: back to IDLE, toggles cleared, no response.
    cmd_if.req_op0   = OpPush;
    cmd_if.req_data0 = 8'h99;
    cmd_if.req_valid = 2'b01;
    wait_accept(gr);
    tick();
    cmd_if.req_valid = 2'b00;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_guard_busy", 32'(busy), 32'd0);
    check("rst_guard_tog", 32'(tog), 32'd0);
    seen_vld = 2'b00;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      seen_vld = seen_vld | cmd_if.rsp_valid;
    end
    check("rst_guard_no_rsp", 32'(seen_vld), 32'd0);
    tick();

    // Both requesters always valid: grants alternate starting at 0.
    cmd_if.req_op0   = OpPush;
    cmd_if.req_data0 = 8'h40;
    cmd_if.req_op1   = OpPop;
    cmd_if.req_valid = 2'b11;
    for (int i = 0; i < 6; i++) begin
      wait_accept(gr);
      check("alt_grant", 32'(gr), 32'(i % 2));
      if (i % 2 == 0) push_exp(0, 8'h00, 1'b0, 4'b0001, 4);
      else            push_exp(1, 8'(8'h40 + i / 2), 1'b0, 4'b0010, 4);
      tick();
      if (i % 2 == 0) cmd_if.req_data0 = 8'(8'h40 + i / 2 + 1);
      wait_rsp("alt");
      tick();
    end
    cmd_if.req_valid = 2'b00;

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
